id_operand_stage: RTL
=====================

ID_OPERAND_STAGE -- requirements
Module: id_operand_stage

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; clrn in 1, reset, asynchronous, active-low.
REQ-002 SHALL have inputs id_rs, id_rt in 5 each, source register numbers, also driven to the register file read ports.
REQ-003 SHALL have inputs rf_qa, rf_qb in 32 each, register file read data for id_rs and id_rt.
REQ-004 SHALL have inputs id_use_rs, id_use_rt in 1 each, instruction reads rs/rt; id_valid in 1, ID holds a real instruction.
REQ-005 SHALL have inputs id_imm in 32, id_wn in 5, id_wreg, id_m2reg, id_wmem, id_aluimm in 1 each, and id_aluc in 4 (decoded controls).
REQ-006 SHALL have forwarding inputs: ex_wn in 5, ex_wreg, ex_m2reg in 1, ex_res in 32; mm_wn in 5, mm_wreg in 1, mm_res in 32; wb_wn in 5, wb_wreg in 1, wb_d in 32.
REQ-007 SHALL have inputs hold in 1, EX frozen by a multi-cycle unit (FPU); flush in 1, kill the ID instruction (taken branch).
REQ-008 SHALL have output stall out 1, combinational; IF/ID and PC must not advance while high.
REQ-009 SHALL have registered outputs e_a, e_b, e_imm out 32 each; e_wn out 5; e_wreg, e_m2reg, e_wmem, e_aluimm, e_valid out 1 each; e_aluc out 4.

Function
REQ-010 SHALL compute operand A per source, register 0 never forwarded, first match wins: EX match (ex_wreg, ex_wn==id_rs, !ex_m2reg) -> ex_res; MEM match -> mm_res; WB match -> wb_d; else rf_qa.
REQ-011 SHALL compute operand B identically using id_rt and rf_qb.
REQ-012 SHALL include WB forwarding because the register file writes at the clock edge ending the cycle in which ID reads it.
REQ-013 SHALL raise load-use hazard luh when id_valid, ex_wreg, ex_m2reg, ex_wn!=0, and ex_wn matches id_rs with id_use_rs or id_rt with id_use_rt.
REQ-014 SHALL drive stall = hold | (luh & !flush).
REQ-015 SHALL update the ID/EX register at each rising edge by priority: hold -> keep all contents; flush -> bubble; luh -> bubble; else load forwarded operands and ID controls, e_valid = id_valid.
REQ-016 Bubble SHALL mean e_wreg, e_m2reg, e_wmem, e_valid = 0; data fields and e_aluc are don't-care but SHALL be 0.
REQ-017 Flush SHALL be held by its source while hold is high; a flush coincident with hold SHALL take effect on the first edge with hold low.
REQ-018 A luh stall SHALL last exactly one cycle when no other event occurs, since the load then moves to MEM and REQ-010 forwards mm_res.
REQ-019 Operands SHALL be re-evaluated every cycle during hold, so values written back meanwhile are picked up on release.
REQ-020 Latency: ID inputs to e_* outputs one clock; stall zero clocks.

Reset
REQ-021 clrn low SHALL asynchronously clear every e_* output to 0 (ID/EX holds a bubble); stall follows its inputs.
REQ-022 Reset released mid-stream SHALL leave no stale instruction: the first post-reset edge loads per REQ-015.

Structure
REQ-023 Forward-select encoding (RF, EX, MEM, WB) and the 4-bit ALU control width SHALL be constants in the shared CPU package.
REQ-024 One sub-module, fwd_mux, SHALL implement REQ-010 and be instantiated twice (A and B); hazard logic and the register stay in the top.

Verification
REQ-025 ex_wreg=1, ex_m2reg=0, ex_wn=5, ex_res=0x11, id_rs=5, rf_qa=0x99 -> e_a=0x11 next edge, stall=0.
REQ-026 ex and mm both write r7 (ex_res=0xA, mm_res=0xB), id_rt=7 -> e_b=0xA; with ex_wreg=0 -> e_b=0xB; with only wb_wn=7, wb_d=0xC -> 0xC.
REQ-027 ex load to r3, id_rs=3, id_use_rs=1 -> stall=1 one cycle, e_valid=0 then; next cycle mm_wn=3, mm_res=0x42 -> e_a=0x42, e_valid=1.
REQ-028 Same load with id_use_rs=0, or ex_wn=0 -> stall=0, no bubble.
REQ-029 hold=1 for 3 cycles with flush=1 throughout -> e_* unchanged, stall=1; first edge after hold falls -> bubble.
REQ-030 clrn pulsed low between edges while e_wreg=1 -> all e_* read 0 immediately, before any clock edge.

Source files
------------

// File: rtl/id_operand_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_operand_stage_pkg
// Description : Shared CPU constants and types for the ID operand stage.
// Revision    : 1.0
// ============================================================================
package id_operand_stage_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int ALUC_W = 4;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_EX = 2'd1,
        FWD_MM = 2'd2,
        FWD_WB = 2'd3
    } fwd_sel_e;

    typedef struct packed {
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] wn;
        logic              wreg;
        logic              m2reg;
        logic              wmem;
        logic              aluimm;
        logic              valid;
        logic [ALUC_W-1:0] aluc;
    } idex_t;

endpackage
`default_nettype wire

// File: rtl/id_operand_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : fwd_mux
// Description : Operand source select; r0 never forwarded, EX > MEM > WB > RF.
// Revision    : 1.0
// ============================================================================
module fwd_mux
    import id_operand_stage_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  logic [XLEN-1:0]   rf_q,
    input  logic [REG_AW-1:0] ex_wn,
    input  logic              ex_wreg,
    input  logic              ex_m2reg,
    input  logic [XLEN-1:0]   ex_res,
    input  logic [REG_AW-1:0] mm_wn,
    input  logic              mm_wreg,
    input  logic [XLEN-1:0]   mm_res,
    input  logic [REG_AW-1:0] wb_wn,
    input  logic              wb_wreg,
    input  logic [XLEN-1:0]   wb_d,
    output logic [XLEN-1:0]   q
);

    fwd_sel_e sel;

    // A load in EX has no data yet; the hazard logic stalls, so fall through.
    always_comb begin
        sel = FWD_RF;
        if (src != '0) begin
            if (ex_wreg && !ex_m2reg && (ex_wn == src))
                sel = FWD_EX;
            else if (mm_wreg && (mm_wn == src))
                sel = FWD_MM;
            else if (wb_wreg && (wb_wn == src))
                sel = FWD_WB;
        end
    end

    always_comb begin
        q = rf_q;
        case (sel)
            FWD_EX:  q = ex_res;
            FWD_MM:  q = mm_res;
            FWD_WB:  q = wb_d;
            default: q = rf_q;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/id_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_operand_stage
// Description : Operand forwarding, load-use hazard detection and ID/EX register.
// Revision    : 1.0
// ============================================================================
module id_operand_stage
    import id_operand_stage_pkg::*;
(
    input  logic              clk,
    input  logic              clrn,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [XLEN-1:0]   rf_qa,
    input  logic [XLEN-1:0]   rf_qb,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_wn,
    input  logic              id_wreg,
    input  logic              id_m2reg,
    input  logic              id_wmem,
    input  logic              id_aluimm,
    input  logic [ALUC_W-1:0] id_aluc,
    input  logic [REG_AW-1:0] ex_wn,
    input  logic              ex_wreg,
    input  logic              ex_m2reg,
    input  logic [XLEN-1:0]   ex_res,
    input  logic [REG_AW-1:0] mm_wn,
    input  logic              mm_wreg,
    input  logic [XLEN-1:0]   mm_res,
    input  logic [REG_AW-1:0] wb_wn,
    input  logic              wb_wreg,
    input  logic [XLEN-1:0]   wb_d,
    input  logic              hold,
    input  logic              flush,
    output logic              stall,
    output logic [XLEN-1:0]   e_a,
    output logic [XLEN-1:0]   e_b,
    output logic [XLEN-1:0]   e_imm,
    output logic [REG_AW-1:0] e_wn,
    output logic              e_wreg,
    output logic              e_m2reg,
    output logic              e_wmem,
    output logic              e_aluimm,
    output logic              e_valid,
    output logic [ALUC_W-1:0] e_aluc
);

    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic            luh;
    idex_t           idex_d;
    idex_t           idex_q;

    fwd_mux u_fwd_a (
        .src(id_rs), .rf_q(rf_qa),
        .ex_wn(ex_wn), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_res(ex_res),
        .mm_wn(mm_wn), .mm_wreg(mm_wreg), .mm_res(mm_res),
        .wb_wn(wb_wn), .wb_wreg(wb_wreg), .wb_d(wb_d),
        .q(opa)
    );

    fwd_mux u_fwd_b (
        .src(id_rt), .rf_q(rf_qb),
        .ex_wn(ex_wn), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_res(ex_res),
        .mm_wn(mm_wn), .mm_wreg(mm_wreg), .mm_res(mm_res),
        .wb_wn(wb_wn), .wb_wreg(wb_wreg), .wb_d(wb_d),
        .q(opb)
    );

    assign luh = id_valid && ex_wreg && ex_m2reg && (ex_wn != '0) &&
                 (((ex_wn == id_rs) && id_use_rs) || ((ex_wn == id_rt) && id_use_rt));

    assign stall = hold | (luh & ~flush);

    always_comb begin
        idex_d = idex_q;
        if (!hold) begin
            if (flush || luh) begin
                idex_d = '0;
            end else begin
                idex_d.a      = opa;
                idex_d.b      = opb;
                idex_d.imm    = id_imm;
                idex_d.wn     = id_wn;
                idex_d.wreg   = id_wreg;
                idex_d.m2reg  = id_m2reg;
                idex_d.wmem   = id_wmem;
                idex_d.aluimm = id_aluimm;
                idex_d.valid  = id_valid;
                idex_d.aluc   = id_aluc;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            idex_q <= '0;
        else
            idex_q <= idex_d;
    end

    assign e_a      = idex_q.a;
    assign e_b      = idex_q.b;
    assign e_imm    = idex_q.imm;
    assign e_wn     = idex_q.wn;
    assign e_wreg   = idex_q.wreg;
    assign e_m2reg  = idex_q.m2reg;
    assign e_wmem   = idex_q.wmem;
    assign e_aluimm = idex_q.aluimm;
    assign e_valid  = idex_q.valid;
    assign e_aluc   = idex_q.aluc;

endmodule
`default_nettype wire
